// File: rtl/vx_pe_share_pkg.sv
// Shared types and constants for the PE share block.
//   pe_share_tag_t    : source-slice tag for the default two-slice build
//   PERF_CTR_BITS     : width of the tag-full stall counter
//   pe_share_dataw()  : execute/commit payload width for a given lane count
//   pe_share_next_idx : round-robin successor of a slice index
// Payload layout (LSB first): eop, sop, pid, lane data.
package vx_pe_share_pkg;

  localparam int unsigned PE_SHARE_DEF_REQS  = 2;
  localparam int unsigned PERF_CTR_BITS      = 16;
  localparam int unsigned PE_SHARE_PID_BITS  = 2;
  localparam int unsigned PE_SHARE_LANE_BITS = 8;
  localparam int unsigned PE_SHARE_EOP_BIT   = 0;
  localparam int unsigned PE_SHARE_SOP_BIT   = 1;

  typedef logic [$clog2(PE_SHARE_DEF_REQS)-1:0] pe_share_tag_t;

  function automatic int unsigned pe_share_dataw(int unsigned num_lanes);
    return num_lanes * PE_SHARE_LANE_BITS + PE_SHARE_PID_BITS + 2;
  endfunction

  function automatic int unsigned pe_share_next_idx(int unsigned idx, int unsigned n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/vx_pe_share_tag_fifo.sv
// In-order tag FIFO recording which slice owns each outstanding PE request.
//   clk, reset : clock, asynchronous active-low reset
//   push/push_tag : enqueue a tag (ignored when full)
//   pop        : dequeue the head (ignored when empty)
//   head       : tag at the head of the queue
//   full/empty : occupancy flags
//   count      : number of stored tags (0..Depth)
module vx_pe_share_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned TagW  = 1,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            push,
  input  logic [TagW-1:0] push_tag,
  input  logic            pop,
  output logic [TagW-1:0] head,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [TagW-1:0] mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_tag;
  end

endmodule

// File: rtl/vx_pe_share.sv
// Shares one processing element between NUM_REQS execute slices.
// Requests are arbitrated (round-robin or fixed priority) onto the single PE input; a
// multi-beat packet locks the grant until its eop. Each accepted sop pushes the source
// index into an in-order tag FIFO, and PE commits are steered to the slice at its head.
//   clk, reset                          : clock, asynchronous active-low reset
//   execute_in_valid/data/ready  [N]    : requests from slices
//   execute_out_valid/data/ready        : request to the shared PE
//   commit_in_valid/data/ready          : results from the PE
//   commit_out_valid/data/ready  [N]    : results back to the owning slice
//   perf_stall_cycles, perf_pending     : only when PE_SHARE_PERF_EN is defined
module vx_pe_share
  import vx_pe_share_pkg::*;
#(
  parameter int unsigned NUM_REQS    = 2,
  parameter int unsigned NUM_LANES   = 4,
  parameter int unsigned MAX_PENDING = 4,
  parameter string       ARBITER     = "R",
  localparam int unsigned DATAW = pe_share_dataw(NUM_LANES),
  localparam int unsigned TAG_W = $clog2(NUM_REQS),
  localparam int unsigned CNT_W = $clog2(MAX_PENDING + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NUM_REQS-1:0]                execute_in_valid,
  input  logic [NUM_REQS-1:0][DATAW-1:0]     execute_in_data,
  output logic [NUM_REQS-1:0]                execute_in_ready,
  output logic                               execute_out_valid,
  output logic [DATAW-1:0]                   execute_out_data,
  input  logic                               execute_out_ready,
  input  logic                               commit_in_valid,
  input  logic [DATAW-1:0]                   commit_in_data,
  output logic                               commit_in_ready,
  output logic [NUM_REQS-1:0]                commit_out_valid,
  output logic [NUM_REQS-1:0][DATAW-1:0]     commit_out_data,
  input  logic [NUM_REQS-1:0]                commit_out_ready
`ifdef PE_SHARE_PERF_EN
  ,
  output logic [PERF_CTR_BITS-1:0]           perf_stall_cycles,
  output logic [CNT_W-1:0]                   perf_pending
`endif
);

  logic             lock_q, lock_d;
  logic [TAG_W-1:0] lock_idx_q, lock_idx_d;
  logic [TAG_W-1:0] rr_q, rr_d;
  logic [TAG_W-1:0] grant_idx;
  logic             grant_any;
  logic             out_fire, out_sop, out_eop;
  logic             commit_fire;
  logic [TAG_W-1:0] head_tag;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] tag_count;

  // Arbitration: a held lock overrides the arbiter even if the locked slice idles.
  always_comb begin
    int unsigned      start;
    logic [TAG_W-1:0] idx;
    grant_idx = lock_idx_q;
    grant_any = 1'b0;
    start     = (ARBITER == "P") ? 0 : 32'(rr_q);
    idx       = '0;
    if (lock_q) begin
      grant_any = execute_in_valid[lock_idx_q];
    end else begin
      for (int unsigned k = 0; k < NUM_REQS; k++) begin
        idx = TAG_W'((start + k) % NUM_REQS);
        if (!grant_any && execute_in_valid[idx]) begin
          grant_any = 1'b1;
          grant_idx = idx;
        end
      end
    end
  end

  // A full tag FIFO blocks the request path outright; commits never feed back into ready.
  assign execute_out_valid = reset & grant_any & ~fifo_full;
  assign execute_out_data  = execute_in_data[grant_idx];
  assign out_fire          = execute_out_valid & execute_out_ready;
  assign out_sop           = execute_out_data[PE_SHARE_SOP_BIT];
  assign out_eop           = execute_out_data[PE_SHARE_EOP_BIT];

  always_comb begin
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      execute_in_ready[i] = reset & grant_any & (grant_idx == TAG_W'(i)) & ~fifo_full
                            & execute_out_ready;
    end
  end

  always_comb begin
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    rr_d       = rr_q;
    if (out_fire) begin
      if (!lock_q && out_sop && !out_eop) begin
        lock_d     = 1'b1;
        lock_idx_d = grant_idx;
      end
      if (out_eop) begin
        lock_d = 1'b0;
        rr_d   = TAG_W'(pe_share_next_idx(32'(grant_idx), NUM_REQS));
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      rr_q       <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      rr_q       <= rr_d;
    end
  end

  // Response path: steer every beat to the head owner; pop only on the final beat.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQS; i++) begin
      commit_out_valid[i] = reset & commit_in_valid & ~fifo_empty & (head_tag == TAG_W'(i));
      commit_out_data[i]  = commit_in_data;
    end
  end

  assign commit_in_ready = reset & ~fifo_empty & commit_out_ready[head_tag];
  assign commit_fire     = commit_in_valid & commit_in_ready;

  vx_pe_share_tag_fifo #(
    .Depth (MAX_PENDING),
    .TagW  (TAG_W)
  ) u_tag_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (out_fire & out_sop),
    .push_tag (grant_idx),
    .pop      (commit_fire & commit_in_data[PE_SHARE_EOP_BIT]),
    .head     (head_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (tag_count)
  );

  // The PE must never return a result with nothing outstanding.
  a_commit_without_tag: assert property (
    @(posedge clk) disable iff (!reset) !(commit_in_valid && fifo_empty)
  ) else $error("commit valid with empty tag FIFO");

`ifdef PE_SHARE_PERF_EN
  logic [PERF_CTR_BITS-1:0] stall_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
    end else if (|execute_in_valid && fifo_full && stall_q != '1) begin
      stall_q <= stall_q + PERF_CTR_BITS'(1);
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_pending      = tag_count;
`else
  logic unused_tag_count;
  assign unused_tag_count = ^tag_count;
`endif

endmodule
